// File: rtl/fir_filter_multilane.sv
// -----------------------------------------------------------------------------
// fir_filter_multilane
//
// Time-multiplexed FIR filter. One sample is processed at a time: after a
// sample is accepted, the filter walks over its taps LANES at a time, so a
// result needs LENGTH/LANES accumulate cycles plus one cycle to present it.
// Coefficients are signed and can be rewritten at run time while idle.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (clears all state)
//   FIR_input     signed input sample
//   input_valid   a sample is present on FIR_input
//   input_ready   the filter can take a sample this cycle (idle only)
//   coef_wr_en    coefficient write strobe (honoured only while idle)
//   coef_wr_addr  tap index; tap 0 multiplies the newest sample
//   coef_wr_data  signed coefficient value
//   output_valid  one-cycle pulse: FIR_output carries a new result
//   FIR_output    signed sum over k of h[k]*x[n-k]; held until next result
// -----------------------------------------------------------------------------
module fir_filter_multilane #(
    parameter int WIDTH      = 8,
    parameter int COEF_WIDTH = 8,
    parameter int LENGTH     = 100,
    parameter int LANES      = 4,
    parameter int OUT_WIDTH  = 23
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [WIDTH-1:0]       FIR_input,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic                          coef_wr_en,
    input  logic [$clog2(LENGTH)-1:0]     coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0]  coef_wr_data,
    output logic                          output_valid,
    output logic signed [OUT_WIDTH-1:0]   FIR_output
);

    localparam int N      = LENGTH / LANES;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W  = $clog2(LENGTH);
    localparam int PROD_W = WIDTH + COEF_WIDTH;

    // Catch unusable parameter sets at elaboration time.
    if (LENGTH % LANES != 0) begin : g_bad_lanes
        $error("LENGTH must be a multiple of LANES");
    end
    if (OUT_WIDTH <= PROD_W) begin : g_bad_width
        $error("OUT_WIDTH must be wider than one product");
    end

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t                        state;
    logic signed [WIDTH-1:0]       delay_line [LENGTH];
    logic signed [COEF_WIDTH-1:0]  coef       [LENGTH];
    logic signed [OUT_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]              count;

    logic [IDX_W-1:0]              tap_idx    [LANES];
    logic signed [PROD_W-1:0]      product    [LANES];
    logic signed [OUT_WIDTH-1:0]   lane_sum;

    logic                          accept;
    logic                          coef_write;

    // A sample is taken only while idle; input_ready is high exactly then.
    // Coefficient writes are likewise confined to idle so that a sum in
    // flight never sees a mixture of old and new coefficients.
    always_comb begin
        accept     = (state == IDLE) && input_valid && input_ready;
        coef_write = (state == IDLE) && coef_wr_en &&
                     (int'(coef_wr_addr) < LENGTH);
    end

    // Each MAC cycle handles the group of taps count*LANES .. count*LANES+LANES-1.
    // Products are sign-extended to the accumulator width before summing,
    // and the width is sized so the running sum cannot overflow.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            tap_idx[l] = IDX_W'(int'(count) * LANES + l);
            product[l] = delay_line[tap_idx[l]] * coef[tap_idx[l]];
            lane_sum   = lane_sum +
                         {{(OUT_WIDTH - PROD_W){product[l][PROD_W-1]}}, product[l]};
        end
    end

    // Delay line: newest sample enters at tap 0 on every accepted sample.
    // Its contents carry over from one sample to the next; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LENGTH; k++) begin
                delay_line[k] <= '0;
            end
        end else if (accept) begin
            delay_line[0] <= FIR_input;
            for (int k = 1; k < LENGTH; k++) begin
                delay_line[k] <= delay_line[k-1];
            end
        end
    end

    // Coefficient memory. A write in the same cycle as an accepted sample
    // lands before the first MAC cycle, so that sample already uses it.
    // Addresses past the last tap are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LENGTH; k++) begin
                coef[k] <= '0;
            end
        end else if (coef_write) begin
            coef[coef_wr_addr] <= coef_wr_data;
        end
    end

    // Control FSM: IDLE waits for a sample, MAC runs N accumulate cycles,
    // DONE raises output_valid for one cycle. The final group is added
    // straight into FIR_output so the result is ready as DONE begins.
    // Reset from any state returns to IDLE and discards the sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
            FIR_output   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    output_valid <= 1'b0;
                    if (accept) begin
                        acc         <= '0;
                        count       <= '0;
                        input_ready <= 1'b0;
                        state       <= MAC;
                    end
                end
                MAC: begin
                    if (count == CNT_W'(N - 1)) begin
                        FIR_output   <= acc + lane_sum;
                        output_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        acc   <= acc + lane_sum;
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    output_valid <= 1'b0;
                    input_ready  <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    output_valid <= 1'b0;
                    input_ready  <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_multilane.sv
// -----------------------------------------------------------------------------
// tb_fir_filter_multilane
//
// Drives four copies of the filter (LANES = 1, 2, 4, 5, LENGTH = 100) from
// the same inputs and compares every result with a direct convolution of
// the sample history against the coefficient table. Copy 2 (LANES = 4) is
// also used on its own for back-pressure behaviour.
// -----------------------------------------------------------------------------
module tb_fir_filter_multilane;

    localparam int LENGTH  = 100;
    localparam int NDUT    = 4;
    localparam int MAIN    = 2;
    localparam int MAX_LAT = LENGTH + 1;

    function automatic int lanesOf(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 5;
    endfunction

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic signed [7:0]   FIR_input = '0;
    logic                input_valid = 1'b0;
    logic                coef_wr_en = 1'b0;
    logic [6:0]          coef_wr_addr = '0;
    logic signed [7:0]   coef_wr_data = '0;
    logic [NDUT-1:0]     rdy;
    logic [NDUT-1:0]     ov;
    logic signed [22:0]  outv [NDUT];

    int checks = 0;
    int errors = 0;

    int coefM [LENGTH];
    int histM [LENGTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fir_filter_multilane #(
            .WIDTH     (8),
            .COEF_WIDTH(8),
            .LENGTH    (LENGTH),
            .LANES     ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5),
            .OUT_WIDTH (23)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .FIR_input   (FIR_input),
            .input_valid (input_valid),
            .input_ready (rdy[g]),
            .coef_wr_en  (coef_wr_en),
            .coef_wr_addr(coef_wr_addr),
            .coef_wr_data(coef_wr_data),
            .output_valid(ov[g]),
            .FIR_output  (outv[g])
        );
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain convolution over the stored history.
    function automatic longint modelSum();
        longint s = 0;
        for (int k = 0; k < LENGTH; k++) s += longint'(coefM[k]) * longint'(histM[k]);
        return s;
    endfunction

    task automatic modelShift(input int s);
        for (int k = LENGTH - 1; k > 0; k--) histM[k] = histM[k-1];
        histM[0] = s;
    endtask

    task automatic modelClear();
        for (int k = 0; k < LENGTH; k++) begin
            coefM[k] = 0;
            histM[k] = 0;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        modelClear();
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("reset_ready_L%0d", lanesOf(i)), rdy[i], 1);
            checkOutput($sformatf("reset_valid_L%0d", lanesOf(i)), ov[i], 0);
            checkOutput($sformatf("reset_out_L%0d", lanesOf(i)), outv[i], 0);
        end
    endtask

    // Coefficient write while every copy is idle.
    task automatic writeCoef(input int addr, input int data);
        coef_wr_addr = 7'(addr);
        coef_wr_data = 8'(data);
        coef_wr_en   = 1'b1;
        tick();
        coef_wr_en   = 1'b0;
        if (addr < LENGTH) coefM[addr] = data;
    endtask

    // Present one sample to all copies and check each result and latency.
    // wrMode 1: coefficient write in the handshake cycle (takes effect now).
    // wrMode 2: coefficient write during the second MAC cycle (ignored).
    task automatic applyStimulus(input int sample, input int wrMode, input int wrAddr, input int wrData);
        longint expected;
        int     lat [NDUT];
        int     waitCnt;
        waitCnt = 0;
        while (rdy != '1 && waitCnt < 300) begin
            tick();
            waitCnt++;
        end
        if (rdy != '1) checkOutput("idle_wait", rdy, 15);
        FIR_input   = 8'(sample);
        input_valid = 1'b1;
        if (wrMode == 1) begin
            coef_wr_addr = 7'(wrAddr);
            coef_wr_data = 8'(wrData);
            coef_wr_en   = 1'b1;
            if (wrAddr < LENGTH) coefM[wrAddr] = wrData;
        end
        modelShift(sample);
        expected = modelSum();
        tick();
        input_valid = 1'b0;
        coef_wr_en  = 1'b0;
        checkOutput("busy_ready", rdy[MAIN], 0);
        for (int i = 0; i < NDUT; i++) lat[i] = 0;
        for (int cnt = 1; cnt <= MAX_LAT + 1; cnt++) begin
            for (int i = 0; i < NDUT; i++) begin
                if (ov[i] && lat[i] == 0) begin
                    lat[i] = cnt;
                    checkOutput($sformatf("result_L%0d", lanesOf(i)), outv[i], expected);
                end else if (lat[i] != 0 && cnt == lat[i] + 1) begin
                    checkOutput($sformatf("pulse_L%0d", lanesOf(i)), ov[i], 0);
                end
            end
            if (wrMode == 2 && cnt == 2) begin
                coef_wr_addr = 7'(wrAddr);
                coef_wr_data = 8'(wrData);
                coef_wr_en   = 1'b1;
            end
            tick();
            coef_wr_en = 1'b0;
        end
        for (int i = 0; i < NDUT; i++)
            checkOutput($sformatf("latency_L%0d", lanesOf(i)), lat[i], LENGTH / lanesOf(i) + 1);
    endtask

    initial begin
        int expQ[$];
        int accepted, readyHigh, lastHs, pulses, s;
        bit hs;

        $display("[TB] start");
        doReset();

        // Impulse response with h[k] = k+1 walks out 1..100.
        for (int k = 0; k < LENGTH; k++) writeCoef(k, k + 1);
        writeCoef(127, 55);
        writeCoef(100, -77);
        applyStimulus(1, 0, 0, 0);
        for (int n = 1; n < LENGTH; n++) applyStimulus(0, 0, 0, 0);
        checkOutput("impulse_last", outv[MAIN], 100);

        // Coefficient write during MAC is ignored; in IDLE it sticks.
        applyStimulus(3, 2, 0, -5);
        writeCoef(0, -5);
        applyStimulus(7, 0, 0, 0);
        applyStimulus(2, 1, 1, -9);

        // Full-scale negative accumulation without wrap.
        for (int k = 0; k < LENGTH; k++) writeCoef(k, 127);
        for (int n = 0; n < LENGTH; n++) applyStimulus(-128, 0, 0, 0);
        checkOutput("full_scale", outv[MAIN], -1625600);

        // Continuous input_valid on the LANES=4 copy: one accept per N+2 cycles.
        accepted  = 0;
        readyHigh = 0;
        lastHs    = -1;
        s = int'($urandom_range(0, 255)) - 128;
        FIR_input   = 8'(s);
        input_valid = 1'b1;
        for (int c = 0; c < 4 * 27; c++) begin
            if (ov[MAIN]) begin
                if (expQ.size() > 0) checkOutput("hold_result", outv[MAIN], expQ.pop_front());
                else checkOutput("hold_extra_valid", ov[MAIN], 0);
            end
            hs = rdy[MAIN];
            if (hs) begin
                readyHigh++;
                modelShift(s);
                expQ.push_back(int'(modelSum()));
                if (lastHs >= 0) checkOutput("hold_spacing", c - lastHs, 27);
                lastHs = c;
                accepted++;
            end
            tick();
            if (hs) begin
                s = int'($urandom_range(0, 255)) - 128;
                FIR_input = 8'(s);
            end
        end
        input_valid = 1'b0;
        checkOutput("hold_accepted", accepted, 4);
        checkOutput("hold_ready_cycles", readyHigh, 4);
        checkOutput("hold_pending", expQ.size(), 0);
        for (int c = 0; c < 110; c++) tick();

        // Reset in the middle of MAC drops the sample and all coefficients.
        doReset();
        for (int k = 0; k < LENGTH; k++) writeCoef(k, k + 1);
        FIR_input   = 8'(1);
        input_valid = 1'b1;
        tick();
        input_valid = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelClear();
        checkOutput("rst_mid_ready", rdy, 15);
        pulses = 0;
        for (int c = 0; c < 110; c++) begin
            if (ov != '0) pulses++;
            tick();
        end
        checkOutput("rst_mid_no_pulse", pulses, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_zero_coef", outv[MAIN], 0);
        for (int k = 0; k < LENGTH; k++) writeCoef(k, k + 1);
        applyStimulus(0, 0, 0, 0);

        // Random coefficients and samples, all lane counts against the model.
        doReset();
        for (int k = 0; k < LENGTH; k++) writeCoef(k, int'($urandom_range(0, 255)) - 128);
        for (int n = 0; n < 25; n++) begin
            if (n % 8 == 7) s = (n % 16 == 7) ? -128 : 127;
            else s = int'($urandom_range(0, 255)) - 128;
            applyStimulus(s, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
